// File: rtl/deserializer_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Optional parity framing is enabled with DESERIALIZER_PARITY_EN.
package deserializer_pkg;

`ifdef DESERIALIZER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int DEF_DATA_W = 16;

  function automatic int frame_len(int data_w, bit parity_en);
    return data_w + (parity_en ? 1 : 0);
  endfunction

  function automatic int cnt_width(int data_w, bit parity_en);
    return $clog2(frame_len(data_w, parity_en) + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_DATA_W, PARITY_EN);

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel stage: MSB-first bits into DATA_W-bit words.
// DESERIALIZER_PARITY_EN appends an even-parity bit to each frame.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic              deser_data_val_o
`ifdef DESERIALIZER_PARITY_EN
  ,
  output logic              deser_parity_err_o
`endif
);

  localparam int FLEN = frame_len(DATA_W, PARITY_EN);
  localparam int CW   = cnt_width(DATA_W, PARITY_EN);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FLEN-1:0]   sh_q, sh_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              val_q, val_d;
`ifdef DESERIALIZER_PARITY_EN
  logic              err_q, err_d;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    done_d = 1'b0;
    data_d = data_q;
    val_d  = 1'b0;
`ifdef DESERIALIZER_PARITY_EN
    err_d  = err_q;
`endif
    // sh_q still holds the finished frame one edge after completion
    if (done_q) begin
      data_d = sh_q[FLEN-1 -: DATA_W];
      val_d  = 1'b1;
`ifdef DESERIALIZER_PARITY_EN
      err_d  = ^sh_q;
`endif
    end
    if (data_val_i) begin
      sh_d = {sh_q[FLEN-2:0], data_i};
      if (cnt_q == CW'(FLEN - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      done_q <= 1'b0;
      data_q <= '0;
      val_q  <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
      err_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      done_q <= done_d;
      data_q <= data_d;
      val_q  <= val_d;
`ifdef DESERIALIZER_PARITY_EN
      err_q  <= err_d;
`endif
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_val_o = val_q;
`ifdef DESERIALIZER_PARITY_EN
  assign deser_parity_err_o = err_q;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: queue-based frame model, random gaps/words,
// plus width sweep instances at DATA_W=2 and DATA_W=64.
module tb_deserializer;

  localparam int W = 16;
`ifdef DESERIALIZER_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  localparam int FL = W + PEN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, din, dval;
  logic [W-1:0] dout;
  logic dv;
  logic d2, v2, d64, v64;
  logic [1:0] dout2;
  logic [63:0] dout64;
  logic dv2, dv64;
`ifdef DESERIALIZER_PARITY_EN
  logic perr, perr2, perr64;
`endif

  deserializer #(.DATA_W(W)) dut (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval),
    .deser_data_o(dout), .deser_data_val_o(dv)
`ifdef DESERIALIZER_PARITY_EN
    , .deser_parity_err_o(perr)
`endif
  );

  deserializer #(.DATA_W(2)) dut2 (
    .clk_i(clk), .srst_i(srst), .data_i(d2), .data_val_i(v2),
    .deser_data_o(dout2), .deser_data_val_o(dv2)
`ifdef DESERIALIZER_PARITY_EN
    , .deser_parity_err_o(perr2)
`endif
  );

  deserializer #(.DATA_W(64)) dut64 (
    .clk_i(clk), .srst_i(srst), .data_i(d64), .data_val_i(v64),
    .deser_data_o(dout64), .deser_data_val_o(dv64)
`ifdef DESERIALIZER_PARITY_EN
    , .deser_parity_err_o(perr64)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc[$];
  logic [W-1:0] last_word;
  bit last_err;

  // reference model state: accepted bits of the frame in progress
  bit mbits[$];
  bit m_pend, m_val, m_perr, m_pperr;
  logic [W-1:0] m_pword, m_data;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit r, bit v, bit d);
    srst = r; dval = v; din = d;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      mbits.delete();
      m_pend = 0; m_val = 0; m_data = '0; m_perr = 0;
    end else begin
      m_val = 0;
      if (m_pend) begin
        m_val = 1; m_data = m_pword; m_perr = m_pperr; m_pend = 0;
      end
      if (v) begin
        mbits.push_back(d);
        if (mbits.size() == FL) begin
          m_pword = '0;
          for (int i = 0; i < W; i++) m_pword = {m_pword[W-2:0], mbits[i]};
          m_pperr = 0;
          if (PEN == 1) m_pperr = (^m_pword) ^ mbits[W];
          m_pend = 1;
          mbits.delete();
        end
      end
    end
    chk("val", dv, m_val);
    chk("data", dout, m_data);
`ifdef DESERIALIZER_PARITY_EN
    chk("perr", perr, m_perr);
    if (dv) last_err = perr;
`endif
    if (dv) begin
      pulses++;
      last_word = dout;
      pulse_cyc.push_back(cyc);
    end
  endtask

  task automatic send_word(logic [W-1:0] w, bit par, int gapmax);
    for (int i = W - 1; i >= 0; i--) begin
      int g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
      for (int k = 0; k < g; k++) step(0, 0, $urandom_range(0, 1));
      step(0, 1, w[i]);
    end
    if (PEN == 1) step(0, 1, par);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, $urandom_range(0, 1));
  endtask

  initial begin
    logic [W-1:0] rw;
    logic [63:0] w64;
    int p0;
    d2 = 0; v2 = 0; d64 = 0; v64 = 0;
    last_word = '0; last_err = 0;

    for (int i = 0; i < 3; i++) step(1, i[0], $urandom_range(0, 1));
    chk("rst_pulses", pulses, 0);
    chk("rst_val2", dv2, 0);
    chk("rst_data64", dout64, 0);

    p0 = pulses;
    send_word(16'hA5C3, ^16'hA5C3, 0);
    idle(3);
    chk("a5c3_n", pulses - p0, 1);
    chk("a5c3_w", last_word, 16'hA5C3);

    p0 = pulses;
    send_word(16'h8001, ^16'h8001, 5);
    idle(3);
    chk("gap_n", pulses - p0, 1);
    chk("gap_w", last_word, 16'h8001);

    p0 = pulses;
    pulse_cyc.delete();
    send_word(16'hFFFF, ^16'hFFFF, 0);
    send_word(16'h0000, 1'b0, 0);
    send_word(16'h1234, ^16'h1234, 0);
    idle(3);
    chk("b2b_n", pulses - p0, 3);
    chk("b2b_w", last_word, 16'h1234);
    if (pulse_cyc.size() == 3) begin
      chk("b2b_gap1", pulse_cyc[1] - pulse_cyc[0], FL);
      chk("b2b_gap2", pulse_cyc[2] - pulse_cyc[1], FL);
    end

    for (int i = 0; i < 9; i++) step(0, 1, $urandom_range(0, 1));
    step(1, 1, 1);
    p0 = pulses;
    send_word(16'h00F0, ^16'h00F0, 0);
    idle(3);
    chk("mid_n", pulses - p0, 1);
    chk("mid_w", last_word, 16'h00F0);

    for (int n = 0; n < 20; n++) begin
      rw = W'($urandom);
      p0 = pulses;
      send_word(rw, ^rw, $urandom_range(0, 3));
      idle(2);
      chk("rnd_n", pulses - p0, 1);
      chk("rnd_w", last_word, rw);
    end

`ifdef DESERIALIZER_PARITY_EN
    send_word(16'h0003, 1'b0, 0);
    idle(2);
    chk("par_ok_w", last_word, 16'h0003);
    chk("par_ok_e", last_err, 0);
    send_word(16'h0007, 1'b0, 0);
    idle(2);
    chk("par_bad_w", last_word, 16'h0007);
    chk("par_bad_e", last_err, 1);
`endif

    // width sweep: DATA_W=2 then DATA_W=64, main DUT idle
    srst = 0; dval = 0;
    v2 = 1; d2 = 1; @(posedge clk); #1;
    d2 = 0; @(posedge clk); #1;
    if (PEN == 1) begin d2 = 1; @(posedge clk); #1; end
    v2 = 0;
    chk("w2_early", dv2, 0);
    @(posedge clk); #1;
    chk("w2_val", dv2, 1);
    chk("w2_data", dout2, 2'b10);
`ifdef DESERIALIZER_PARITY_EN
    chk("w2_perr", perr2, 0);
`endif
    @(posedge clk); #1;
    chk("w2_once", dv2, 0);

    w64 = 64'hDEAD_BEEF_0123_4567;
    for (int i = 63; i >= 0; i--) begin
      v64 = 1; d64 = w64[i]; @(posedge clk); #1;
    end
    if (PEN == 1) begin d64 = ^w64; @(posedge clk); #1; end
    v64 = 0;
    @(posedge clk); #1;
    chk("w64_val", dv64, 1);
    chk("w64_data", dout64, 64'hDEAD_BEEF_0123_4567);
`ifdef DESERIALIZER_PARITY_EN
    chk("w64_perr", perr64, 0);
`endif
    @(posedge clk); #1;
    chk("w64_once", dv64, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
